// File: rtl/comp_code_stack.sv
// comp_code_stack: a live comparison-code register backed by a small LIFO
// save stack. A push saves the live code and a pop restores it. cc_in can
// also load the live code in the same cycle as a push or a pop.
// Illegal operations are ignored: a push when the stack is full, a pop when
// it is empty, and a push and a pop together.
// Optional feature macro: COMP_CODE_STACK_ERR_EN. It enables the sticky
// ovf/unf error flags. When it is not defined, both flags stay 0.
module comp_code_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             cc_in,
  input  logic                         cc_we,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             cc_out,
  output logic [WIDTH-1:0]             cc_top,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] cc_nxt;
  logic [LW-1:0]    level_nxt;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_idx  = IW'(level);
  assign top_idx = IW'(level - LW'(1));
  assign cc_top  = empty ? '0 : stack[top_idx];

  // Decide which stack operation is legal, and compute the next live code and level
  always_comb begin
    push_ok   = push & ~pop & ~full;
    pop_ok    = pop & ~push & ~empty;
    cc_nxt    = cc_out;
    level_nxt = level;
    if (push_ok) begin
      level_nxt = level + LW'(1);
    end else if (pop_ok) begin
      level_nxt = level - LW'(1);
      cc_nxt    = stack[top_idx];
    end
    if (cc_we) begin
      cc_nxt = cc_in;
    end
  end

  // Live code register, level counter and stack storage
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cc_out <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      cc_out <= cc_nxt;
      level  <= level_nxt;
      if (push_ok) begin
        stack[wr_idx] <= cc_out;
      end
    end
  end

`ifdef COMP_CODE_STACK_ERR_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = push & (pop | full);
  assign unf_set = pop & (push | empty);

  // Sticky error flags; a new error in the same cycle beats err_clr
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_comp_code_stack.sv
// Testbench for comp_code_stack. The reference model uses a queue for the
// save stack. The expected ovf/unf values follow COMP_CODE_STACK_ERR_EN.
module tb_comp_code_stack;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

`ifdef COMP_CODE_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] cc_in;
  logic             cc_we;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] cc_out;
  logic [WIDTH-1:0] cc_top;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_stack [$];
  logic [WIDTH-1:0] m_cc;
  bit               m_ovf;
  bit               m_unf;

  comp_code_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .cc_in  (cc_in),
    .cc_we  (cc_we),
    .push   (push),
    .pop    (pop),
    .err_clr(err_clr),
    .cc_out (cc_out),
    .cc_top (cc_top),
    .level  (level),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_stack.delete();
    m_cc  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply the rules for one clock edge: the queue tail is the top of stack
  task automatic modelStep(input bit we, input logic [WIDTH-1:0] din,
                           input bit pu, input bit po, input bit clr);
    logic [WIDTH-1:0] restored;
    bit               set_o;
    bit               set_u;
    bit               did_pop;
    set_o   = 1'b0;
    set_u   = 1'b0;
    did_pop = 1'b0;
    restored = m_cc;
    if (pu && po) begin
      set_o = 1'b1;
      set_u = 1'b1;
    end else if (pu) begin
      if (m_stack.size() == DEPTH) set_o = 1'b1;
      else m_stack.push_back(m_cc);
    end else if (po) begin
      if (m_stack.size() == 0) set_u = 1'b1;
      else begin
        restored = m_stack.pop_back();
        did_pop  = 1'b1;
      end
    end
    if (we) m_cc = din;
    else if (did_pop) m_cc = restored;
    if (ERR_EN) begin
      m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [WIDTH-1:0] exp_top;
    exp_top = (m_stack.size() == 0) ? '0 : m_stack[m_stack.size()-1];
    checkOutput({tag, ".cc_out"}, 32'(cc_out), 32'(m_cc));
    checkOutput({tag, ".cc_top"}, 32'(cc_top), 32'(exp_top));
    checkOutput({tag, ".level"},  32'(level),  32'(m_stack.size()));
    checkOutput({tag, ".full"},   32'(full),   32'(m_stack.size() == DEPTH));
    checkOutput({tag, ".empty"},  32'(empty),  32'(m_stack.size() == 0));
    checkOutput({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
    checkOutput({tag, ".unf"},    32'(unf),    32'(m_unf));
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare against the model
  task automatic applyStimulus(input string tag, input bit we, input logic [WIDTH-1:0] din,
                               input bit pu, input bit po, input bit clr);
    cc_we   = we;
    cc_in   = din;
    push    = pu;
    pop     = po;
    err_clr = clr;
    @(posedge CLK);
    modelStep(we, din, pu, po, clr);
    #1;
    checkAll(tag);
  endtask

  // Pulse reset low between edges, check that it acts asynchronously, then release
  task automatic midCycleReset(input string tag);
    cc_we = 0; push = 0; pop = 0; err_clr = 0; cc_in = '0;
    #1;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async_cc_out"}, 32'(cc_out), 32'd0);
    checkOutput({tag, ".async_level"},  32'(level),  32'd0);
    checkAll(tag);
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    checkAll({tag, ".post"});
  endtask

  initial begin
    reset = 1'b0;
    cc_we = 0; cc_in = '0; push = 0; pop = 0; err_clr = 0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkAll("reset");
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    #1;

    // Load a code with an empty stack
    applyStimulus("load10", 1, 2'b10, 0, 0, 0);
    checkOutput("load10.fixed_cc", 32'(cc_out), 32'd2);
    checkOutput("load10.fixed_empty", 32'(empty), 32'd1);

    // A push with cc_we saves the old code; a pop restores it
    applyStimulus("load01", 1, 2'b01, 0, 0, 0);
    applyStimulus("pushwe", 1, 2'b11, 1, 0, 0);
    checkOutput("pushwe.fixed_cc",  32'(cc_out), 32'd3);
    checkOutput("pushwe.fixed_top", 32'(cc_top), 32'd1);
    checkOutput("pushwe.fixed_lvl", 32'(level),  32'd1);
    applyStimulus("pop1", 0, 2'b00, 0, 1, 0);
    checkOutput("pop1.fixed_cc",  32'(cc_out), 32'd1);
    checkOutput("pop1.fixed_lvl", 32'(level),  32'd0);

    // Push codes 0,1,2,3,1; the fifth push overflows
    begin
      logic [WIDTH-1:0] codes [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      for (int i = 0; i < 5; i++) begin
        applyStimulus("ovf.load", 1, codes[i], 0, 0, 0);
        applyStimulus("ovf.push", 0, 2'b00, 1, 0, 0);
        if (i == 3) checkOutput("ovf.full4", 32'(full), 32'd1);
      end
    end
    checkOutput("ovf.fixed_lvl", 32'(level),  32'd4);
    checkOutput("ovf.fixed_top", 32'(cc_top), 32'd3);
    checkOutput("ovf.fixed_ovf", 32'(ovf),    32'(ERR_EN));
    applyStimulus("ovf.clr", 0, 2'b00, 0, 0, 1);
    checkOutput("ovf.fixed_clr", 32'(ovf), 32'd0);
    // Draining the stack shows that the contents survived the rejected push
    for (int i = 0; i < 4; i++) applyStimulus("ovf.drain", 0, 2'b00, 0, 1, 0);
    checkOutput("ovf.fixed_bottom", 32'(cc_out), 32'd0);

    // An underflow on an empty stack; then push and pop in the same cycle at level 2
    applyStimulus("unf.load", 1, 2'b10, 0, 0, 0);
    applyStimulus("unf.pop", 0, 2'b00, 0, 1, 0);
    checkOutput("unf.fixed_unf", 32'(unf),    32'(ERR_EN));
    checkOutput("unf.fixed_cc",  32'(cc_out), 32'd2);
    applyStimulus("unf.clr", 0, 2'b00, 0, 0, 1);
    applyStimulus("pp.push", 0, 2'b00, 1, 0, 0);
    applyStimulus("pp.push", 0, 2'b00, 1, 0, 0);
    applyStimulus("pp.both", 1, 2'b01, 1, 1, 0);
    checkOutput("pp.fixed_lvl", 32'(level), 32'd2);
    checkOutput("pp.fixed_ovf", 32'(ovf),   32'(ERR_EN));
    checkOutput("pp.fixed_unf", 32'(unf),   32'(ERR_EN));
    // A new error in the same cycle beats err_clr
    applyStimulus("pp.setclr", 0, 2'b00, 1, 1, 1);

    // A pop with cc_we at level 3, then an asynchronous reset
    applyStimulus("pw.push", 0, 2'b00, 1, 0, 0);
    applyStimulus("pw.pop", 1, 2'b00, 0, 1, 0);
    checkOutput("pw.fixed_cc",  32'(cc_out), 32'd0);
    checkOutput("pw.fixed_lvl", 32'(level),  32'd2);
    applyStimulus("pw.load", 1, 2'b11, 0, 0, 0);
    midCycleReset("rst1");

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        midCycleReset("rnd.rst");
      end else begin
        applyStimulus("rnd", 1'($urandom_range(0, 1)), WIDTH'($urandom),
                      ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
                      ($urandom_range(0, 9) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_code_stack.md
COMP_CODE_STACK -- requirements
Module: comp_code_stack

Interface
REQ-001 Parameter WIDTH, default 2: bit width of the comparison code.
REQ-002 Parameter DEPTH, default 4: number of save-stack entries; legal range 1..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 cc_in  input  WIDTH  new comparison code.
REQ-006 cc_we  input  1  load cc_in into live code register.
REQ-007 push  input  1  save live code onto stack.
REQ-008 pop  input  1  restore top of stack into live code register.
REQ-009 err_clr  input  1  clear sticky error flags.
REQ-010 cc_out  output  WIDTH  live comparison code, registered.
REQ-011 cc_top  output  WIDTH  top stack entry, combinational peek; 0 when empty.
REQ-012 level  output  $clog2(DEPTH+1)  number of valid stack entries.
REQ-013 full / empty  output  1 each  level==DEPTH / level==0.
REQ-014 ovf / unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-015 Live register and stack update together in one cycle; all outputs except cc_top are registered.
REQ-016 cc_we only: cc_out <= cc_in next edge; level unchanged.
REQ-017 No op asserted: cc_out, stack and level hold.
REQ-018 push, not full: stack[level] <= pre-edge cc_out; level +1.
REQ-019 push with cc_we: saved entry is the pre-edge cc_out; cc_out <= cc_in.
REQ-020 pop, not empty: cc_out <= stack[level-1]; level -1.
REQ-021 pop with cc_we: cc_we wins; cc_out <= cc_in, top entry discarded, level -1.
REQ-022 push when full: stack and level unchanged; ovf <= 1; cc_we still honoured.
REQ-023 pop when empty: level unchanged; cc_out holds (or takes cc_in if cc_we); unf <= 1.
REQ-024 push and pop in same cycle: stack and level unchanged; ovf <= 1 and unf <= 1; cc_we still honoured.
REQ-025 err_clr clears ovf and unf next edge; a same-cycle new error sets its flag instead (set beats clear).
REQ-026 Stack entries are addressed by level; there is no pointer wrap-around, and rejected pushes never overwrite entries.

Reset
REQ-027 reset==0 asynchronously forces cc_out=0, level=0, ovf=0, unf=0, all stack entries 0.
REQ-028 Reset during any operation aborts it; the first operation after release acts on reset state.
REQ-029 Reset deassertion is synchronised externally; the block takes no action on release.

Configuration
REQ-030 Macro COMP_CODE_STACK_ERR_EN: when defined, ovf/unf behave per REQ-022..025.
REQ-031 Without COMP_CODE_STACK_ERR_EN, ovf and unf are tied 0, err_clr is ignored, and illegal operations are still ignored per REQ-022..024.

Verification
REQ-032 Reset, WIDTH=2, DEPTH=4; cc_we=1 cc_in=2'b10 -> cc_out=2'b10 next cycle, level=0, empty=1.
REQ-033 cc_out=2'b01; push+cc_we cc_in=2'b11 -> cc_out=2'b11, level=1, cc_top=2'b01; pop -> cc_out=2'b01, level=0.
REQ-034 Five pushes of codes 0,1,2,3,1 -> level=4, full=1 after fourth; fifth ignored, ovf=1, cc_top=3; err_clr -> ovf=0.
REQ-035 Empty stack; pop -> unf=1, cc_out unchanged; push+pop same cycle with level=2 -> level stays 2, ovf=unf=1.
REQ-036 level=3; pop+cc_we cc_in=2'b00 -> cc_out=2'b00, level=2; then reset pulse low mid-cycle -> cc_out=0, level=0 immediately, without waiting for CLK.
REQ-037 Build without COMP_CODE_STACK_ERR_EN, repeat REQ-034 -> ovf stays 0, stack contents identical.
